delta_dram_read_arbiter: RTL

//  Shares the single 32-bit DRAM read port between NUM_REQ loader controllers (input, weight, ...).

---
 rtl/delta_dram_read_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/delta_dram_read_arbiter.sv
// Round-robin arbiter sharing one DRAM read port among NUM_REQ loader controllers,
// with an optional per-requester lock that keeps the grant across a two-word line read.
module delta_dram_read_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4,
  localparam int GID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W   = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_lock,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      DRAM_Read,
  output logic [ADDR_W-1:0]         DRAM_Address,
  input  logic [DATA_W-1:0]         DRAM_ReadData,
  input  logic                      DRAM_DataReady,
  output logic                      grant_valid,
  output logic [GID_W-1:0]          grant_id,
  output logic                      protocol_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0] grant_id_q, grant_id_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             perr_q, perr_d;

  logic             in_grant;
  logic             cur_read;
  logic             cur_lock;
  logic [GID_W-1:0] next_id;
  logic [GID_W-1:0] pick;
  logic             found;
  int               idx;

  assign in_grant  = (state_q == ST_GRANT);
  assign cur_read  = req_read[grant_id_q];
  assign cur_lock  = req_lock[grant_id_q];
  assign next_id   = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  assign req_rdata    = DRAM_ReadData;
  assign DRAM_Read    = in_grant && cur_read;
  assign DRAM_Address = in_grant ? req_addr[int'(grant_id_q)*ADDR_W +: ADDR_W] : '0;
  assign grant_valid  = (state_q == ST_GRANT) || (state_q == ST_HOLD);
  assign grant_id     = grant_id_q;
  assign protocol_err = perr_q;

  always_comb begin
    req_ready = '0;
    if (in_grant && DRAM_DataReady) req_ready[grant_id_q] = 1'b1;
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_read[idx]) begin
        found = 1'b1;
        pick  = GID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    hold_cnt_d = hold_cnt_q;
    perr_d     = perr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_id_d = pick;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (DRAM_DataReady) begin
          if (cur_lock) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end else begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_id;
          end
        end else if (!cur_read) begin
          perr_d   = 1'b1;
          state_d  = ST_IDLE;
          rr_ptr_d = next_id;
        end
      end
      ST_HOLD: begin
        if (cur_read) begin
          state_d = ST_GRANT;
        end else if (!cur_lock || hold_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_id;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      hold_cnt_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      hold_cnt_q <= hold_cnt_d;
      perr_q     <= perr_d;
    end
  end

endmodule
